// File: rtl/wb_dram_tester.sv
// Wishbone classic master memory tester: writes NUM_WORDS patterned words from
// a base address, reads them back, and reports mismatches, bus errors and timeouts.
module wb_dram_tester #(
  parameter int WORD_SIZE      = 256,
  parameter int ADDR_WIDTH     = 25,
  parameter int NUM_WORDS      = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ERR_WIDTH      = 16
) (
  input  logic                   sys_clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [7:0]             seed,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic [ERR_WIDTH-1:0]   err_count,
  output logic [ADDR_WIDTH-1:0]  first_err_addr,
  output logic                   wb_cyc,
  output logic                   wb_stb,
  output logic                   wb_we,
  output logic [ADDR_WIDTH-1:0]  wb_adr,
  output logic [WORD_SIZE-1:0]   wb_dat_w,
  output logic [WORD_SIZE/8-1:0] wb_sel,
  input  logic [WORD_SIZE-1:0]   wb_dat_r,
  input  logic                   wb_ack,
  input  logic                   wb_err,
  output logic [2:0]             state_dbg
);

  // Handshake: cyc/stb/we/adr/dat_w/sel are raised at a request edge and held
  // unchanged until the first edge that sees ack or err (err wins); the bus then
  // idles for at least one cycle before the next request.

  localparam int LANES = WORD_SIZE / 32;
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] LFSR_POLY = 32'h0040_0007;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_NEXT, RD_REQ, RD_CHECK, FINISH} state_t;

  state_t                 state;
  logic [1:0]             mode_q;
  logic [7:0]             seed_q;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [IDX_W-1:0]       idx;
  logic [31:0]            lfsr;
  logic [TMR_W-1:0]       timer;
  logic [WORD_SIZE-1:0]   rd_data;
  logic                   skip_cmp;
  logic                   err_seen;

  function automatic logic [31:0] lfsr_init(input logic [7:0] s);
    return (s == 8'd0) ? 32'd1 : {4{s}};
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], 1'b0} ^ (s[31] ? LFSR_POLY : 32'd0);
  endfunction

  function automatic logic [WORD_SIZE-1:0] pattern(input logic [1:0] m, input logic [7:0] s,
      input logic odd, input logic [ADDR_WIDTH-1:0] a, input logic [31:0] l);
    logic [WORD_SIZE-1:0] w;
    case (m)
      2'd0:    w = {(WORD_SIZE/8){s}};
      2'd1:    w = odd ? ~{(WORD_SIZE/8){s}} : {(WORD_SIZE/8){s}};
      2'd2:    w = {LANES{32'(a)}};
      default: w = {LANES{l}};
    endcase
    return w;
  endfunction

  function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] c);
    return (&c) ? c : c + ERR_WIDTH'(1);
  endfunction

  // wb_adr doubles as the running base+idx, so it is reused for compares and capture.
  logic                  last_word;
  logic                  timed_out;
  logic                  mismatch;
  logic [IDX_W-1:0]      nxt_idx;
  logic [ADDR_WIDTH-1:0] nxt_adr;
  logic [31:0]           nxt_lfsr;

  assign last_word = (idx == LAST_IDX);
  assign timed_out = (timer == TMR_LAST);
  assign nxt_idx   = idx + IDX_W'(1);
  assign nxt_adr   = wb_adr + ADDR_WIDTH'(1);
  assign nxt_lfsr  = lfsr_step(lfsr);
  assign mismatch  = !skip_cmp && (rd_data != pattern(mode_q, seed_q, idx[0], wb_adr, lfsr));
  assign pass      = done && (err_count == '0) && !timeout;
  assign state_dbg = state;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      mode_q         <= '0;
      seed_q         <= '0;
      base_q         <= '0;
      idx            <= '0;
      lfsr           <= '0;
      timer          <= '0;
      rd_data        <= '0;
      skip_cmp       <= 1'b0;
      err_seen       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      wb_cyc         <= 1'b0;
      wb_stb         <= 1'b0;
      wb_we          <= 1'b0;
      wb_adr         <= '0;
      wb_dat_w       <= '0;
      wb_sel         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_q         <= mode;
            seed_q         <= seed;
            base_q         <= base_addr;
            err_count      <= '0;
            first_err_addr <= '0;
            err_seen       <= 1'b0;
            done           <= 1'b0;
            timeout        <= 1'b0;
            busy           <= 1'b1;
            idx            <= '0;
            lfsr           <= lfsr_init(seed);
            timer          <= '0;
            wb_cyc         <= 1'b1;
            wb_stb         <= 1'b1;
            wb_we          <= 1'b1;
            wb_sel         <= '1;
            wb_adr         <= base_addr;
            wb_dat_w       <= pattern(mode, seed, 1'b0, base_addr, lfsr_init(seed));
            state          <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (wb_ack || wb_err) begin
            if (wb_err) err_count <= sat_inc(err_count);
            wb_cyc <= 1'b0;
            wb_stb <= 1'b0;
            wb_we  <= 1'b0;
            wb_sel <= '0;
            state  <= WR_NEXT;
          end else if (timed_out) begin
            wb_cyc  <= 1'b0;
            wb_stb  <= 1'b0;
            wb_we   <= 1'b0;
            wb_sel  <= '0;
            timeout <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= FINISH;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        WR_NEXT: begin
          timer  <= '0;
          wb_cyc <= 1'b1;
          wb_stb <= 1'b1;
          wb_sel <= '1;
          if (last_word) begin
            // Read phase replays the generator from its initial state.
            idx    <= '0;
            lfsr   <= lfsr_init(seed_q);
            wb_adr <= base_q;
            wb_we  <= 1'b0;
            state  <= RD_REQ;
          end else begin
            idx      <= nxt_idx;
            lfsr     <= nxt_lfsr;
            wb_adr   <= nxt_adr;
            wb_we    <= 1'b1;
            wb_dat_w <= pattern(mode_q, seed_q, nxt_idx[0], nxt_adr, nxt_lfsr);
            state    <= WR_REQ;
          end
        end
        RD_REQ: begin
          if (wb_err) begin
            err_count <= sat_inc(err_count);
            if (!err_seen) begin
              first_err_addr <= wb_adr;
              err_seen       <= 1'b1;
            end
            skip_cmp <= 1'b1;
            wb_cyc   <= 1'b0;
            wb_stb   <= 1'b0;
            wb_sel   <= '0;
            state    <= RD_CHECK;
          end else if (wb_ack) begin
            rd_data  <= wb_dat_r;
            skip_cmp <= 1'b0;
            wb_cyc   <= 1'b0;
            wb_stb   <= 1'b0;
            wb_sel   <= '0;
            state    <= RD_CHECK;
          end else if (timed_out) begin
            wb_cyc  <= 1'b0;
            wb_stb  <= 1'b0;
            wb_sel  <= '0;
            timeout <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= FINISH;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        RD_CHECK: begin
          if (mismatch) begin
            err_count <= sat_inc(err_count);
            if (!err_seen) begin
              first_err_addr <= wb_adr;
              err_seen       <= 1'b1;
            end
          end
          if (last_word) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FINISH;
          end else begin
            idx    <= nxt_idx;
            lfsr   <= nxt_lfsr;
            wb_adr <= nxt_adr;
            timer  <= '0;
            wb_cyc <= 1'b1;
            wb_stb <= 1'b1;
            wb_we  <= 1'b0;
            wb_sel <= '1;
            state  <= RD_REQ;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
